imem_controller: RTL
====================

Name: imem_controller

Overview:
- Sequences and shares the single-port instruction memory between the fetch stage (reads) and a program loader (writes from debug/UART).
- After reset, runs a boot-load phase that fills memory, then releases the core and serves one fetch per cycle with fixed 1-cycle read latency.
- Handles loader-over-fetch arbitration, pipeline flush of in-flight reads, and out-of-range/misaligned PC faults.
- Sits between the PC register/fetch stage and the instruction memory array.

Parameters:
DEPTH, 256, memory depth in 32-bit words
ADDR_W, 8, word-address width (log2 DEPTH)
BOOT_LOAD, 1, 1: start in LOAD state after reset; 0: start in RUN (memory preinitialised from program.hex)
NOP_INSTR, 32'h00000013, instruction returned on fault (addi x0,x0,0)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  reset, asynchronous assert, active-low
Load_Valid  in  1  loader write request
Load_Addr  in  ADDR_W  loader word address
Load_Data  in  32  loader write data
Load_Done  in  1  loader finished (pulse)
Load_Ready  out  1  loader write accepted this cycle
Fetch_Req  in  1  fetch stage requests instruction at Fetch_PC
Fetch_PC  in  32  byte address
Fetch_Flush  in  1  kill in-flight read (branch taken)
Fetch_Ready  out  1  fetch request accepted this cycle
Instr_Valid  out  1  Instr/Instr_PC valid (one-cycle pulse)
Instr  out  32  returned instruction
Instr_PC  out  32  PC of returned instruction
Fetch_Fault  out  1  qualifies Instr_Valid: misaligned or out-of-range PC
Core_Run  out  1  high in RUN; gates pipeline enable
Load_Count  out  ADDR_W+1  words written since reset (saturates at DEPTH)
Mem_Addr  out  ADDR_W  memory word address
Mem_WE  out  1  memory write enable
Mem_RE  out  1  memory read enable
Mem_WData  out  32  memory write data
Mem_RData  in  32  memory read data, valid cycle after Mem_RE

Behaviour:
- Reset (RST_N low, async): state=LOAD if BOOT_LOAD else RUN; Instr_Valid=0, Instr=NOP_INSTR, Instr_PC=0, Fetch_Fault=0, Load_Count=0, read-pending=0. Core_Run reflects state. All Mem_* strobes 0.
- States: LOAD -> RUN on Load_Done. RUN has no exit except reset.
- LOAD: Load_Ready=Load_Valid, Fetch_Ready=0. A write accepted in the same cycle as Load_Done completes; transition takes effect next cycle.
- RUN arbitration: loader has priority. If Load_Valid, the write is issued, Load_Ready=1, Fetch_Ready=0 (fetch stalls). Otherwise Fetch_Ready=1.
- Write: Mem_WE=1, Mem_Addr=Load_Addr, Mem_WData=Load_Data, same cycle (combinational); Load_Count increments, saturating at DEPTH.
- Fetch accepted cycle N (Fetch_Req & Fetch_Ready): if Fetch_PC[1:0]==0 and Fetch_PC[31:2]<DEPTH, Mem_RE=1 and Mem_Addr=Fetch_PC[ADDR_W+1:2]. Cycle N+1: Instr_Valid=1, Instr=Mem_RData, Instr_PC=PC captured at N, Fetch_Fault=0.
- Fault PC at N: no memory access. At N+1: Instr_Valid=1, Fetch_Fault=1, Instr=NOP_INSTR.
- Back-to-back fetches give one Instr_Valid per cycle.
- Instr and Instr_PC hold the last returned values while Instr_Valid=0. They are driven from a holding register updated on each return.
- Fetch_Flush in cycle N+1 (same cycle as return): Instr_Valid forced 0 and the holding register is not updated. A new request in that same cycle is still accepted.
- Fetch_Flush together with an accept in cycle N: the new request is kept. The flush applies only to the read already in flight.
- A write in RUN to an address read the previous cycle does not alter that return. Memory is read-before-write; stale data is the defined result.
- Reset mid-read: pending read is discarded and no Instr_Valid follows.

Test Plan:
- BOOT_LOAD=1: write addr 0..3 = 32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013, then Load_Done -> Core_Run=1 next cycle, Load_Count=4, Fetch_Ready=0 throughout LOAD.
- RUN: fetch PC 0,4,8 back-to-back -> Instr_Valid 3 consecutive cycles with 32'h00500093, 32'h00A00113, 32'h002081B3 and Instr_PC 0,4,8.
- Fetch PC=32'h2 and PC=32'h400 -> Fetch_Fault=1, Instr=32'h00000013, no Mem_RE asserted.
- Load_Valid and Fetch_Req in the same RUN cycle -> write wins, Fetch_Ready=0; fetch accepted next cycle. Read-then-write same address -> old data returned.
- Fetch PC=4, then Fetch_Flush in the return cycle with a new fetch PC=8 -> no valid for 4, valid for 8 next cycle. Reset asserted mid-read -> no Instr_Valid, outputs at reset values.

Source files
------------

// File: rtl/imem_controller.sv
// ============================================================================
// imem_controller : boot-load sequencer and fetch/loader arbiter for the IMEM
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_controller #(
  parameter int          DEPTH     = 256,
  parameter int          ADDR_W    = 8,
  parameter int          BOOT_LOAD = 1,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              CLK,
  input  logic              RST_N,
  // program loader
  input  logic              Load_Valid,
  input  logic [ADDR_W-1:0] Load_Addr,
  input  logic [31:0]       Load_Data,
  input  logic              Load_Done,
  output logic              Load_Ready,
  // fetch stage
  input  logic              Fetch_Req,
  input  logic [31:0]       Fetch_PC,
  input  logic              Fetch_Flush,
  output logic              Fetch_Ready,
  output logic              Instr_Valid,
  output logic [31:0]       Instr,
  output logic [31:0]       Instr_PC,
  output logic              Fetch_Fault,
  output logic              Core_Run,
  output logic [ADDR_W:0]   Load_Count,
  // memory array
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_WE,
  output logic              Mem_RE,
  output logic [31:0]       Mem_WData,
  input  logic [31:0]       Mem_RData
);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam state_e          RESET_STATE = (BOOT_LOAD != 0) ? ST_LOAD : ST_RUN;
  localparam logic [29:0]     DEPTH_WORDS = 30'(DEPTH);
  localparam logic [ADDR_W:0] COUNT_MAX   = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic              pend_fault_q, pend_fault_d;
  logic [31:0]       pend_pc_q, pend_pc_d;
  logic [31:0]       hold_instr_q, hold_instr_d;
  logic [31:0]       hold_pc_q, hold_pc_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic              w_write;
  logic              w_accept;
  logic              w_pc_ok;
  logic              w_read;
  logic              w_return;
  logic [31:0]       w_ret_instr;

  // Strobes are gated by RST_N so nothing reaches the array while reset is held.
  assign w_write  = Load_Valid & RST_N;
  assign w_pc_ok  = (Fetch_PC[1:0] == 2'b00) && (Fetch_PC[31:2] < DEPTH_WORDS);
  assign w_accept = Fetch_Req & Fetch_Ready;
  assign w_read   = w_accept & w_pc_ok;

  // A flush in the return cycle kills only the read already in flight.
  assign w_return    = pend_q & ~Fetch_Flush;
  assign w_ret_instr = pend_fault_q ? NOP_INSTR : Mem_RData;

  always_comb begin
    Load_Ready  = w_write;
    Fetch_Ready = RST_N & (state_q == ST_RUN) & ~Load_Valid;
    Core_Run    = (state_q == ST_RUN);
    Load_Count  = count_q;

    Mem_WE    = w_write;
    Mem_RE    = w_read;
    Mem_WData = w_write ? Load_Data : 32'h0;
    Mem_Addr  = '0;
    if (w_write) begin
      Mem_Addr = Load_Addr;
    end else if (w_read) begin
      Mem_Addr = Fetch_PC[ADDR_W+1:2];
    end

    Instr_Valid = w_return;
    Fetch_Fault = w_return & pend_fault_q;
    Instr       = w_return ? w_ret_instr : hold_instr_q;
    Instr_PC    = w_return ? pend_pc_q   : hold_pc_q;
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = w_accept;
    pend_fault_d = pend_fault_q;
    pend_pc_d    = pend_pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    count_d      = count_q;

    case (state_q)
      ST_LOAD: if (Load_Done) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = RESET_STATE;
    endcase

    if (w_accept) begin
      pend_fault_d = ~w_pc_ok;
      pend_pc_d    = Fetch_PC;
    end

    if (w_return) begin
      hold_instr_d = w_ret_instr;
      hold_pc_d    = pend_pc_q;
    end

    if (w_write && (count_q != COUNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= RESET_STATE;
      pend_q       <= 1'b0;
      pend_fault_q <= 1'b0;
      pend_pc_q    <= 32'h0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= 32'h0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_fault_q <= pend_fault_d;
      pend_pc_q    <= pend_pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      count_q      <= count_d;
    end
  end

endmodule

`default_nettype wire
